lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Sits directly downstream of the load/store unit.
- Converts a single-shot LSU request (pulse plus latched address, data and byte mask) into one AXI4-Lite read or write transaction on the data-memory bus.
- Returns read data and a one-cycle completion pulse that the LSU consumes as its response-valid.
- Supports one outstanding transaction. An optional timeout watchdog converts a hung bus into an error response.

Parameters:
TIMEOUT, 255, cycles a transaction may wait after acceptance before forced error completion; 0 disables the watchdog
TO_W, $clog2(TIMEOUT+1) (min 1), watchdog counter width; derived, do not override

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  LSU request pulse; sampled only in IDLE
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address from core; bits [1:0] dropped on bus
req_wdata  in  32  store data, already lane-rotated by LSU
req_wmask  in  4  byte strobes, already lane-aligned by LSU
resp_valid  out  1  one-cycle completion pulse to LSU
resp_rdata  out  32  raw word read data, valid with resp_valid on loads; 0 for stores
resp_err  out  1  1 with resp_valid when bus returned SLVERR/DECERR or watchdog fired
busy  out  1  high from acceptance until the cycle after resp_valid
awvalid/awready/awaddr  out/in/out  1/1/32  AXI write address channel
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  AXI write data channel
bvalid/bready/bresp  in/out/in  1/1/2  AXI write response channel
arvalid/arready/araddr  out/in/out  1/1/32  AXI read address channel
rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  AXI read data channel

Behaviour:
- Reset, synchronous, checked before all other logic:
  - state = IDLE; all *valid/*ready outputs = 0; resp_rdata = 0; resp_err = 0; busy = 0; watchdog = 0.
  - Reset mid-transaction abandons the transaction immediately. No further handshakes; bus responses arriving later are ignored.
- Request capture:
  - req_valid in IDLE latches addr, wdata, wmask and wen into registers.
  - Bus address = {req_addr[31:2], 2'b00}.
  - req_valid outside IDLE is ignored (LSU never issues one).
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - req_valid & !req_wen -> RD_ADDR, with arvalid = 1 next cycle.
  - req_valid & req_wen -> WR_REQ, with awvalid = 1 and wvalid = 1 next cycle.
- RD_ADDR:
  - arvalid held with stable araddr until arready.
  - On arready -> RD_DATA, arvalid = 0, rready = 1.
- RD_DATA:
  - On rvalid: latch rdata; resp_err = (rresp != 2'b00); -> DONE.
- WR_REQ:
  - AW and W are tracked independently with aw_done/w_done flags.
  - awvalid drops the cycle after the awready handshake; wvalid likewise after wready.
  - Both may complete in the same cycle.
  - When both are done (including a same-cycle finish) -> WR_RESP with bready = 1.
- WR_RESP:
  - On bvalid: resp_err = (bresp != 2'b00); resp_rdata = 0; -> DONE.
- DONE:
  - resp_valid = 1 for exactly this cycle; -> IDLE.
  - busy deasserts at the IDLE entry.
- Latency, zero-wait slave:
  - Load: req_valid at cycle 0, arvalid at cycle 1, rvalid at cycle 2 at the earliest, resp_valid at cycle 3.
  - Store: resp_valid at cycle 3 at the earliest, with bvalid at cycle 2.
- Protocol rules:
  - A valid never drops before its ready.
  - Addr/data/strb stay stable while valid.
  - rready/bready are asserted only in their wait states.
- Watchdog (TIMEOUT > 0):
  - Counter clears at acceptance and increments each cycle in any non-IDLE, non-DONE state.
  - Reaching TIMEOUT forces DONE with resp_err = 1 and resp_rdata = 0.
  - All bus valids/readies drop; the stale bus beat is not tracked (documented limitation).
  - Counter saturates; no wrap.
  - A handshake completing in the same cycle as the timeout wins: normal completion.
- resp_rdata and resp_err hold their last values until the next completion.

Decomposition:
- Shared package bus_pkg: state enum lsu_bus_state_t (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE); constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- One sub-module: bus_watchdog (TIMEOUT param; inputs clear, enable; output expired), reused later by the fetch-side bus master.

Test Plan:
- Load, zero-wait slave: req_addr=0x8000_0006, wen=0; slave returns rdata=0xDEAD_BEEF, OKAY -> araddr=0x8000_0004, resp_valid at cycle 3, resp_rdata=0xDEAD_BEEF, resp_err=0.
- Store with AW before W: awready at cycle 1, wready at cycle 4, bvalid at cycle 5 OKAY; wdata=0x1122_3344, wstrb=4'b0100 -> awvalid low from cycle 2, wvalid low from cycle 5, resp_valid at cycle 6, resp_rdata=0.
- Store with W before AW, and a same-cycle AW+W case -> exactly one AW and one W handshake each, bready only after both complete.
- Error response: load with rresp=2'b11 -> resp_valid with resp_err=1; following OKAY load returns resp_err=0.
- Watchdog, TIMEOUT=8: arready never asserted -> resp_valid at cycle 9 after acceptance, resp_err=1, arvalid=0 afterwards, busy=0 the next cycle.
- Reset mid-write (asserted while in WR_RESP) -> next cycle all outputs 0, state IDLE; a late bvalid produces no resp_valid; a new load then completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the data-side and fetch-side bus masters:
//   lsu_bus_state_t : transaction FSM states
//   RESP_*          : AXI4-Lite response codes
//   resp_is_err()   : maps an xRESP code onto the single error bit the LSU sees
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } lsu_bus_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY (including EXOKAY, which this bus never uses)
  // is reported to the core as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_master_if
// AXI4-Lite data-memory bus between the LSU bus master and the memory slave.
//   master modport : drives AW/W/AR valids + payloads, bready, rready
//   slave  modport : drives awready, wready, arready, B and R channels
// ---------------------------------------------------------------------------
interface lsu_bus_master_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Counts cycles a bus transaction spends waiting and flags when the budget
// is used up. Shared by the load/store and fetch bus masters.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart the count (transaction accepted)
//   enable       : count this cycle (transaction is waiting on the bus)
//   expired      : this waiting cycle is the TIMEOUT-th one; the owner must
//                  force completion at the coming edge
// TIMEOUT = 0 removes the counter and expired is tied low.
// ---------------------------------------------------------------------------
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clock, reset, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_on
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count_q, count_d;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
      count_d = count_q;
      if (clear) begin
        count_d = '0;
      end else if (enable && (count_q != LIMIT)) begin
        count_d = count_q + 1'b1;  // saturates at LIMIT, never wraps
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same edge regardless of statement order.
    always_ff @(posedge clock) begin
      if (reset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    // The count is the number of waiting cycles already completed, so the
    // one that takes it to LIMIT is the cycle where it reads LIMIT-1.
    assign expired = enable && !clear && (count_q >= (LIMIT - 1'b1));
  end

endmodule

// File: rtl/lsu_bus_master.sv
// ---------------------------------------------------------------------------
// lsu_bus_master
// Turns one LSU request pulse into a single AXI4-Lite read or write and
// returns a one-cycle completion pulse with read data and an error flag.
// One transaction in flight; a watchdog converts a hung bus into an error.
//   clock, reset   : system clock, synchronous active-high reset
//   req_valid      : request pulse, only looked at in IDLE
//   req_wen        : 1 = store, 0 = load
//   req_addr       : byte address; the bus sees it word aligned
//   req_wdata/wmask: store data and byte strobes, already lane aligned
//   resp_valid     : one-cycle completion pulse
//   resp_rdata     : read word on loads, 0 on stores and timeouts (held)
//   resp_err       : bus error response or watchdog expiry (held)
//   busy           : acceptance through the DONE cycle
//   bus            : AXI4-Lite master port
// ---------------------------------------------------------------------------
module lsu_bus_master
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_wen,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [3:0]              req_wmask,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic                    busy,
  lsu_bus_master_if.master        bus
);

  lsu_bus_state_t state_q;

  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        aw_done_q, w_done_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        resp_valid_q, resp_err_q, busy_q;
  logic [31:0] resp_rdata_q;

  logic accept, aw_hs, w_hs, progress, wd_enable, wd_expired, timeout_fire;

  // The byte offset never reaches the bus; the LSU has already lane-aligned
  // data and strobes.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign accept    = (state_q == IDLE) && req_valid;
  assign aw_hs     = awvalid_q && bus.awready;
  assign w_hs      = wvalid_q && bus.wready;
  assign wd_enable = state_q inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // A handshake landing in the expiry cycle lets the transaction move on
  // instead of being killed.
  always_comb begin
    progress = 1'b0;
    case (state_q)
      RD_ADDR: progress = bus.arready;
      RD_DATA: progress = bus.rvalid;
      WR_REQ:  progress = aw_hs || w_hs;
      WR_RESP: progress = bus.bvalid;
      default: progress = 1'b0;
    endcase
  end

  assign timeout_fire = wd_expired && !progress;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;

      if (timeout_fire) begin
        // Abandon the bus: any beat still in flight is simply not tracked.
        awvalid_q    <= 1'b0;
        wvalid_q     <= 1'b0;
        bready_q     <= 1'b0;
        arvalid_q    <= 1'b0;
        rready_q     <= 1'b0;
        resp_err_q   <= 1'b1;
        resp_rdata_q <= '0;
        resp_valid_q <= 1'b1;
        state_q      <= DONE;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              addr_q    <= req_addr[31:2];
              wdata_q   <= req_wdata;
              wmask_q   <= req_wmask;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              busy_q    <= 1'b1;
              if (req_wen) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= WR_REQ;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= RD_ADDR;
              end
            end
          end

          RD_ADDR: begin
            if (bus.arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= RD_DATA;
            end
          end

          RD_DATA: begin
            if (bus.rvalid) begin
              rready_q     <= 1'b0;
              resp_rdata_q <= bus.rdata;
              resp_err_q   <= resp_is_err(bus.rresp);
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end
          end

          WR_REQ: begin
            // AW and W complete independently, possibly in the same cycle.
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
              bready_q <= 1'b1;
              state_q  <= WR_RESP;
            end
          end

          WR_RESP: begin
            if (bus.bvalid) begin
              bready_q     <= 1'b0;
              resp_rdata_q <= '0;
              resp_err_q   <= resp_is_err(bus.bresp);
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end
          end

          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.awvalid = awvalid_q;
  assign bus.awaddr  = {addr_q, 2'b00};
  assign bus.wvalid  = wvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wmask_q;
  assign bus.bready  = bready_q;
  assign bus.arvalid = arvalid_q;
  assign bus.araddr  = {addr_q, 2'b00};
  assign bus.rready  = rready_q;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_master
// Drives LSU requests against a behavioural AXI4-Lite slave with
// per-transaction channel delays and response codes. Expected responses
// come from a word-addressed memory model updated at request level and are
// queued at issue; a monitor pops and compares on every resp_valid.
// ---------------------------------------------------------------------------
module tb_lsu_bus_master;
  import bus_pkg::*;

  localparam int TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  lsu_bus_master_if axi ();

  lsu_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .bus        (axi)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory contents --------------------------------------
  function automatic logic [31:0] init_word(input logic [29:0] idx);
    return ({2'b00, idx} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] model_mem [logic [29:0]];
  logic [31:0] slave_mem [logic [29:0]];

  function automatic logic [31:0] model_read(input logic [29:0] idx);
    return model_mem.exists(idx) ? model_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] slave_read(input logic [29:0] idx);
    return slave_mem.exists(idx) ? slave_mem[idx] : init_word(idx);
  endfunction

  task automatic model_write(input logic [29:0] idx, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] w;
    w = model_read(idx);
    for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
    model_mem[idx] = w;
  endtask

  // ---------------- scoreboard -------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   resp_cnt  = 0;
  int   resp_cyc  = 0;
  int   issue_cyc = 0;

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("busy_with_resp", 32'(busy), 32'd1);
      end
    end
  end

  // ---------------- behavioural AXI4-Lite slave --------------------------
  int         cfg_aw_d, cfg_w_d, cfg_ar_d, cfg_r_d, cfg_b_d;
  logic [1:0] cfg_resp;
  bit         cfg_ar_hang;
  bit         slave_flush;

  bit          aw_done, w_done, ar_done;
  int          aw_wait, w_wait, ar_wait, r_wait, b_wait;
  logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        awv_p, wv_p, arv_p, rr_p, br_p;
  logic [31:0] awa_p, ara_p, wd_p;
  logic [3:0]  ws_p;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
  int          bready_early = 0, rready_early = 0;

  // Decides readies/valids at the negedge; a handshake is recognised one
  // negedge later from the values both sides held across the posedge.
  always @(negedge clock) begin
    if (slave_flush) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
      axi.rvalid  = 1'b0; axi.rresp  = 2'b00; axi.rdata = '0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; b_wait = 0;
      awv_p = 0; wv_p = 0; arv_p = 0; rr_p = 0; br_p = 0;
      awa_p = '0; ara_p = '0; wd_p = '0; ws_p = '0;
    end else begin
      if (axi.awready && awv_p) begin
        aw_hs_cnt++; aw_done = 1; cap_awaddr = awa_p; axi.awready = 1'b0; aw_wait = 0;
        check("awvalid_drop", 32'(axi.awvalid), 32'd0);
      end
      if (axi.wready && wv_p) begin
        w_hs_cnt++; w_done = 1; cap_wdata = wd_p; cap_wstrb = ws_p; axi.wready = 1'b0; w_wait = 0;
        check("wvalid_drop", 32'(axi.wvalid), 32'd0);
      end
      if (axi.arready && arv_p) begin
        ar_hs_cnt++; ar_done = 1; cap_araddr = ara_p; axi.arready = 1'b0; ar_wait = 0; r_wait = 0;
        check("arvalid_drop", 32'(axi.arvalid), 32'd0);
      end
      if (axi.rvalid && rr_p) begin
        axi.rvalid = 1'b0; ar_done = 0;
      end
      if (axi.bvalid && br_p) begin
        axi.bvalid = 1'b0;
        if (axi.bresp == RESP_OKAY) begin
          logic [31:0] w;
          w = slave_read(cap_awaddr[31:2]);
          for (int b = 0; b < 4; b++) if (cap_wstrb[b]) w[8*b +: 8] = cap_wdata[8*b +: 8];
          slave_mem[cap_awaddr[31:2]] = w;
        end
        aw_done = 0; w_done = 0; b_wait = 0;
      end

      if (axi.bready && !(aw_done && w_done)) bready_early++;
      if (axi.rready && !ar_done) rready_early++;

      if (axi.awvalid && !axi.awready && !aw_done) begin
        if (aw_wait >= cfg_aw_d) axi.awready = 1'b1; else aw_wait++;
      end
      if (axi.wvalid && !axi.wready && !w_done) begin
        if (w_wait >= cfg_w_d) axi.wready = 1'b1; else w_wait++;
      end
      if (axi.arvalid && !axi.arready && !ar_done && !cfg_ar_hang) begin
        if (ar_wait >= cfg_ar_d) axi.arready = 1'b1; else ar_wait++;
      end
      if (ar_done && !axi.rvalid) begin
        if (r_wait >= cfg_r_d) begin
          axi.rvalid = 1'b1; axi.rdata = slave_read(cap_araddr[31:2]); axi.rresp = cfg_resp;
        end else r_wait++;
      end
      if (aw_done && w_done && !axi.bvalid) begin
        if (b_wait >= cfg_b_d) begin
          axi.bvalid = 1'b1; axi.bresp = cfg_resp;
        end else b_wait++;
      end

      awv_p = axi.awvalid; awa_p = axi.awaddr;
      wv_p  = axi.wvalid;  wd_p  = axi.wdata;  ws_p = axi.wstrb;
      arv_p = axi.arvalid; ara_p = axi.araddr;
      rr_p  = axi.rready;  br_p  = axi.bready;
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  // Called at a negedge while the DUT is idle; that cycle is cycle 0.
  task automatic issue(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [1:0] resp, input bit hang);
    exp_t e;
    cfg_resp = resp;
    if (hang) begin
      e.rdata = '0; e.err = 1'b1;
    end else begin
      e.err = (resp != RESP_OKAY);
      if (wen) begin
        e.rdata = '0;
        if (!e.err) model_write(addr[31:2], wdata, mask);
      end else begin
        e.rdata = model_read(addr[31:2]);
      end
    end
    sb_q.push_back(e);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    issue_cyc = cyc;
    @(negedge clock);
    req_valid = 1'b0; req_wen = $urandom_range(0, 1);
    req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_resp(input int start, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (resp_cnt != start) break;
      @(negedge clock);
    end
    if (resp_cnt == start) check("resp_wait_bound", 32'(resp_cnt - start), 32'd1);
    else lat = resp_cyc - issue_cyc;
  endtask

  task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [1:0] resp,
                         input int aw_d, input int w_d, input int ar_d, input int r_d, input int b_d,
                         input bit hang, output int lat);
    int start;
    cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_ar_d = ar_d; cfg_r_d = r_d; cfg_b_d = b_d;
    cfg_ar_hang = hang;
    start = resp_cnt;
    issue(wen, addr, wdata, mask, resp, hang);
    wait_resp(start, lat);
    cfg_ar_hang = 0;
    @(negedge clock);
  endtask

  // ---------------- main sequence ----------------------------------------
  initial begin
    int lat, aw0, w0, cnt0;
    logic [29:0] idx;

    reset = 1'b1; slave_flush = 1; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_r_d = 0; cfg_b_d = 0;
    cfg_resp = RESP_OKAY; cfg_ar_hang = 0;
    repeat (4) @(negedge clock);
    check("reset_ctrl_outputs",
          32'({resp_valid, resp_err, busy, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}),
          32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    slave_flush = 0;
    @(negedge clock);

    // Zero-wait load from an unaligned address.
    idx = 30'h2000_0001;
    model_mem[idx] = 32'hDEAD_BEEF;
    slave_mem[idx] = 32'hDEAD_BEEF;
    run_txn(1'b0, 32'h8000_0006, '0, '0, RESP_OKAY, 0, 0, 0, 0, 0, 0, lat);
    check("load_latency", 32'(lat), 32'd3);
    check("load_araddr", cap_araddr, 32'h8000_0004);

    // Store, AW at cycle 1, W at cycle 4, B at cycle 5.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    run_txn(1'b1, 32'h2000_0012, 32'h1122_3344, 4'b0100, RESP_OKAY, 0, 3, 0, 0, 0, 0, lat);
    check("store_aw_first_latency", 32'(lat), 32'd6);
    check("store_aw_first_aw_count", 32'(aw_hs_cnt - aw0), 32'd1);
    check("store_aw_first_w_count", 32'(w_hs_cnt - w0), 32'd1);
    check("store_awaddr", cap_awaddr, 32'h2000_0010);
    check("store_wdata", cap_wdata, 32'h1122_3344);
    check("store_wstrb", 32'(cap_wstrb), 32'h4);
    run_txn(1'b0, 32'h2000_0010, '0, '0, RESP_OKAY, 0, 0, 1, 1, 0, 0, lat);

    // Store, W first.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    run_txn(1'b1, 32'h2000_0020, 32'hCAFE_F00D, 4'b1111, RESP_OKAY, 3, 0, 0, 0, 0, 0, lat);
    check("store_w_first_latency", 32'(lat), 32'd6);
    check("store_w_first_aw_count", 32'(aw_hs_cnt - aw0), 32'd1);
    check("store_w_first_w_count", 32'(w_hs_cnt - w0), 32'd1);

    // Store, AW and W in the same cycle.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    run_txn(1'b1, 32'h2000_0024, 32'h0BAD_0BAD, 4'b0011, RESP_OKAY, 1, 1, 0, 0, 0, 0, lat);
    check("store_same_cycle_latency", 32'(lat), 32'd4);
    check("store_same_cycle_aw_count", 32'(aw_hs_cnt - aw0), 32'd1);
    check("store_same_cycle_w_count", 32'(w_hs_cnt - w0), 32'd1);
    check("bready_before_both_done", 32'(bready_early), 32'd0);
    run_txn(1'b0, 32'h2000_0024, '0, '0, RESP_OKAY, 0, 0, 0, 0, 0, 0, lat);

    // Error responses, then clean ones.
    run_txn(1'b0, 32'h2000_0030, '0, '0, RESP_DECERR, 0, 0, 0, 0, 0, 0, lat);
    run_txn(1'b0, 32'h2000_0030, '0, '0, RESP_OKAY, 0, 0, 0, 0, 0, 0, lat);
    run_txn(1'b1, 32'h2000_0034, 32'hFFFF_FFFF, 4'b1111, RESP_SLVERR, 0, 0, 0, 0, 0, 0, lat);
    run_txn(1'b0, 32'h2000_0034, '0, '0, RESP_OKAY, 0, 0, 0, 0, 0, 0, lat);

    // Watchdog: AR never accepted.
    cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_r_d = 0; cfg_b_d = 0;
    cfg_ar_hang = 1;
    cnt0 = resp_cnt;
    issue(1'b0, 32'h2000_0040, '0, '0, RESP_OKAY, 1'b1);
    wait_resp(cnt0, lat);
    check("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
    check("timeout_arvalid_in_done", 32'(axi.arvalid), 32'd0);
    check("timeout_busy_in_done", 32'(busy), 32'd1);
    @(negedge clock);
    check("timeout_busy_after", 32'(busy), 32'd0);
    check("timeout_arvalid_after", 32'(axi.arvalid), 32'd0);
    cfg_ar_hang = 0;
    slave_flush = 1; repeat (2) @(negedge clock); slave_flush = 0;
    @(negedge clock);

    // Reset while waiting for B; the late bvalid must be ignored.
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 6;
    cnt0 = resp_cnt;
    issue(1'b1, 32'h2000_0050, 32'h5555_AAAA, 4'b1111, RESP_OKAY, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (axi.bready) break;
      @(negedge clock);
    end
    check("reset_test_reached_wr_resp", 32'(axi.bready), 32'd1);
    reset = 1'b1;
    void'(sb_q.pop_back());
    model_mem.delete(30'(32'h2000_0050 >> 2));
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_ctrl_outputs",
          32'({resp_valid, resp_err, busy, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}),
          32'd0);
    check("mid_reset_resp_rdata", resp_rdata, 32'd0);
    repeat (12) @(negedge clock);
    check("late_bvalid_seen", 32'(ar_hs_cnt >= 0 && aw_done && w_done), 32'd1);
    check("no_resp_after_reset", 32'(resp_cnt - cnt0), 32'd0);
    slave_flush = 1; repeat (2) @(negedge clock); slave_flush = 0;
    @(negedge clock);
    run_txn(1'b0, 32'h2000_0050, '0, '0, RESP_OKAY, 0, 0, 0, 0, 0, 0, lat);
    check("post_reset_load_latency", 32'(lat), 32'd3);

    // Randomised mix over a small address window.
    for (int t = 0; t < 60; t++) begin
      logic [1:0] resp;
      int r;
      logic [31:0] addr;
      r = $urandom_range(0, 7);
      resp = (r == 0) ? RESP_SLVERR : (r == 1) ? RESP_DECERR : RESP_OKAY;
      addr = 32'h1000_0000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), resp,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), 0, lat);
      check("random_min_latency", 32'(lat >= 3), 32'd1);
    end

    check("rready_outside_rd_data", 32'(rready_early), 32'd0);
    check("bready_outside_wr_resp", 32'(bready_early), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: run did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
